// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizes and FSM state encoding for the register-file dump unit
package regfile_pkg;

    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_HOLD = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_dump_unit.sv
// rtl/regfile_dump_unit.sv - walks the register file read port and streams (index, value) beats
// Optional trailing checksum beat enabled by defining REGDUMP_CHECKSUM_EN.
import regfile_pkg::*;

module regfile_dump_unit #(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DATA_W   = RF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_wr_block,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]   out_index_q, out_index_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
`ifdef REGDUMP_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
`ifdef REGDUMP_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            ST_READ: begin
                out_data_d  = rf_rdata;
                out_index_d = cnt_q;
                out_valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                out_last_d  = 1'b0;
`else
                out_last_d  = (cnt_q == LAST_IDX);
`endif
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                    sum_d = sum_q + out_data_q;
                    // Last register accepted: the checksum beat follows without a READ cycle.
                    if (cnt_q == LAST_IDX) begin
                        state_d     = ST_CSUM;
                        out_valid_d = 1'b1;
                        out_index_d = '0;
                        out_data_d  = sum_d;
                        out_last_d  = 1'b1;
                    end
`else
                    if (out_last_q) begin
                        state_d = ST_DONE;
                    end
`endif
                    else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = ST_READ;
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_DONE;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
`ifdef REGDUMP_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign rf_wr_block = busy;
    assign done        = (state_q == ST_DONE);
    assign rf_raddr    = busy ? cnt_q : '0;
    assign out_valid   = out_valid_q;
    assign out_index   = out_index_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;

endmodule
